// File: rtl/bus_controller.sv
// bus_controller: arbitrates two cores' icache/dcache word requests onto a
// single-ported RAM and acts as the responder for dcache coherence snoops,
// including cache-to-cache transfer with simultaneous RAM write-back.
//
// Handshake: a cache holds its request (iREN/dREN/dWEN/cctrans) and its
// address/data stable until its wait line drops.  A wait line is low for
// exactly one cycle per completed word, and the controller leaves the state
// on that same edge.  RAM enables/address are held until ramstate==ACCESS;
// BUSY and ERROR both simply extend the cycle.
module bus_controller (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] iload,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    DREAD  = 3'd2,
    DWRITE = 3'd3,
    SNOOP  = 3'd4,
    XFER1  = 3'd5,
    XFER2  = 3'd6
  } bus_state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  bus_state_t r_state;
  bus_state_t w_next_state;
  logic       r_g;
  logic       w_next_g;
  logic       r_lastgrant;
  logic       w_next_lastgrant;
  logic       r_phase;
  logic       w_next_phase;
  logic       w_pick;
  logic       w_j;
  logic       w_access;
  logic [1:0] w_dreq;

  // The snoop target is always the core that was not granted.
  assign w_j         = ~r_g;
  assign w_access    = (ramstate == RAM_ACCESS);
  assign w_dreq      = dREN | dWEN | cctrans;
  assign o_dbg_state = r_state;

  // State, grant and snoop-phase registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_g         <= 1'b0;
      r_lastgrant <= 1'b0;
      r_phase     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_g         <= w_next_g;
      r_lastgrant <= w_next_lastgrant;
      r_phase     <= w_next_phase;
    end
  end

  // Next-state: dcache-over-icache arbitration with round robin between cores.
  always_comb begin
    w_next_state     = r_state;
    w_next_g         = r_g;
    w_next_lastgrant = r_lastgrant;
    w_next_phase     = r_phase;
    w_pick           = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_dreq) begin
          w_pick           = (&w_dreq) ? ~r_lastgrant : w_dreq[1];
          w_next_g         = w_pick;
          w_next_lastgrant = w_pick;
          w_next_phase     = 1'b0;
          if (cctrans[w_pick])   w_next_state = SNOOP;
          else if (dWEN[w_pick]) w_next_state = DWRITE;
          else                   w_next_state = DREAD;
        end else if (|iREN) begin
          w_pick           = (&iREN) ? ~r_lastgrant : iREN[1];
          w_next_g         = w_pick;
          w_next_lastgrant = w_pick;
          w_next_state     = IFETCH;
        end
      end
      IFETCH, DREAD, DWRITE: begin
        if (w_access) w_next_state = IDLE;
      end
      SNOOP: begin
        // Two fixed cycles; the target answers in the second one.
        if (!r_phase) begin
          w_next_phase = 1'b1;
        end else begin
          w_next_phase = 1'b0;
          if (cctrans[w_j])   w_next_state = XFER1;
          else if (dREN[r_g]) w_next_state = DREAD;
          else                w_next_state = IDLE;
        end
      end
      XFER1: begin
        if (w_access) w_next_state = XFER2;
      end
      XFER2: begin
        if (w_access) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs: decoded from state and grant, completion gated by RAM ACCESS.
  always_comb begin
    iwait       = 2'b11;
    iload       = '0;
    dwait       = 2'b11;
    dload       = '0;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (r_state)
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[r_g];
        if (w_access) begin
          iwait[r_g] = 1'b0;
          iload[r_g] = ramload;
        end
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = daddr[r_g];
        if (w_access) begin
          dwait[r_g] = 1'b0;
          dload[r_g] = ramload;
        end
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[r_g];
        ramstore = dstore[r_g];
        if (w_access) dwait[r_g] = 1'b0;
      end
      SNOOP: begin
        ccwait[w_j]      = 1'b1;
        ccinv[w_j]       = ccwrite[r_g];
        ccsnoopaddr[w_j] = daddr[r_g];
      end
      XFER1, XFER2: begin
        // Modified line: forward to the requester and write back in one go.
        ccwait[w_j] = 1'b1;
        dload[r_g]  = dstore[w_j];
        ramWEN      = 1'b1;
        ramaddr     = daddr[w_j];
        ramstore    = dstore[w_j];
        if (w_access) begin
          dwait[r_g] = 1'b0;
          dwait[w_j] = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_controller.sv
// tb_bus_controller: directed cycle-by-cycle vectors for bus_controller plus
// hand-written sequences for cache-to-cache transfer, reset mid-transfer and
// round-robin fairness.
module tb_bus_controller;

  localparam logic [1:0]  F = 2'd0;
  localparam logic [1:0]  B = 2'd1;
  localparam logic [1:0]  A = 2'd2;
  localparam logic [1:0]  E = 2'd3;
  localparam logic [31:0] LD = 32'hCAFE0000;

  logic             CLK;
  logic             RST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic [1:0]       cctrans;
  logic [1:0]       ccwrite;
  logic [1:0]       ccwait;
  logic [1:0]       ccinv;
  logic [1:0][31:0] ccsnoopaddr;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic [1:0]       ramstate;
  logic [2:0]       dbg_state;

  int n_vec = 0;
  int n_err = 0;

  bus_controller dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .o_dbg_state(dbg_state)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [1:0]  iren, dren, dwen, cct, ccw, rs;
    logic [1:0]  e_iw, e_dw, e_ccw, e_cci;
    logic        e_ren, e_wen;
    logic [31:0] e_ra, e_rst;
    logic [63:0] e_il, e_dl, e_snp;
    logic [2:0]  e_st;
  } vec_t;

  vec_t tbl[$];

  // Inputs for one cycle with idle-state expectations as the starting point.
  function automatic vec_t in_v(input logic rst, input logic [1:0] iren,
                                input logic [1:0] dren, input logic [1:0] dwen,
                                input logic [1:0] cct, input logic [1:0] ccw,
                                input logic [1:0] rs);
    vec_t v;
    v.rst = rst; v.iren = iren; v.dren = dren; v.dwen = dwen;
    v.cct = cct; v.ccw = ccw; v.rs = rs;
    v.e_iw = 2'b11; v.e_dw = 2'b11; v.e_ccw = 2'b00; v.e_cci = 2'b00;
    v.e_ren = 1'b0; v.e_wen = 1'b0; v.e_ra = '0; v.e_rst = '0;
    v.e_il = '0; v.e_dl = '0; v.e_snp = '0; v.e_st = 3'd0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_reqs();
    iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00; cctrans = 2'b00; ccwrite = 2'b00;
    ramstate = F;
  endtask

  task automatic build_table();
    vec_t v;
    // reset held: idle outputs
    v = in_v(1, 0, 0, 0, 0, 0, F); tbl.push_back(v);
    // core 0 ifetch 0x40, two BUSY cycles then ACCESS
    v = in_v(0, 2'b01, 0, 0, 0, 0, B); tbl.push_back(v);
    v = in_v(0, 2'b01, 0, 0, 0, 0, B); v.e_st = 3'd1; v.e_ren = 1; v.e_ra = 32'h40; tbl.push_back(v);
    v = in_v(0, 2'b01, 0, 0, 0, 0, B); v.e_st = 3'd1; v.e_ren = 1; v.e_ra = 32'h40; tbl.push_back(v);
    v = in_v(0, 2'b01, 0, 0, 0, 0, A); v.e_st = 3'd1; v.e_ren = 1; v.e_ra = 32'h40;
    v.e_iw = 2'b10; v.e_il = {32'h0, LD}; tbl.push_back(v);
    // both cores dREN: core 1 first, then core 0
    v = in_v(0, 0, 2'b11, 0, 0, 0, F); tbl.push_back(v);
    v = in_v(0, 0, 2'b11, 0, 0, 0, A); v.e_st = 3'd2; v.e_ren = 1; v.e_ra = 32'h200;
    v.e_dw = 2'b01; v.e_dl = {LD, 32'h0}; tbl.push_back(v);
    v = in_v(0, 0, 2'b01, 0, 0, 0, F); tbl.push_back(v);
    v = in_v(0, 0, 2'b01, 0, 0, 0, A); v.e_st = 3'd2; v.e_ren = 1; v.e_ra = 32'h100;
    v.e_dw = 2'b10; v.e_dl = {32'h0, LD}; tbl.push_back(v);
    // core 1 write, BUSY then ERROR (treated as BUSY) then ACCESS
    v = in_v(0, 0, 0, 2'b10, 0, 0, F); tbl.push_back(v);
    v = in_v(0, 0, 0, 2'b10, 0, 0, B); v.e_st = 3'd3; v.e_wen = 1; v.e_ra = 32'h200; v.e_rst = 32'hB0B0; tbl.push_back(v);
    v = in_v(0, 0, 0, 2'b10, 0, 0, E); v.e_st = 3'd3; v.e_wen = 1; v.e_ra = 32'h200; v.e_rst = 32'hB0B0; tbl.push_back(v);
    v = in_v(0, 0, 0, 2'b10, 0, 0, A); v.e_st = 3'd3; v.e_wen = 1; v.e_ra = 32'h200; v.e_rst = 32'hB0B0;
    v.e_dw = 2'b01; tbl.push_back(v);
    // core 0 iREN+dREN together: dcache first, icache next
    v = in_v(0, 2'b01, 2'b01, 0, 0, 0, F); tbl.push_back(v);
    v = in_v(0, 2'b01, 2'b01, 0, 0, 0, A); v.e_st = 3'd2; v.e_ren = 1; v.e_ra = 32'h100;
    v.e_dw = 2'b10; v.e_dl = {32'h0, LD}; tbl.push_back(v);
    v = in_v(0, 2'b01, 0, 0, 0, 0, F); tbl.push_back(v);
    v = in_v(0, 2'b01, 0, 0, 0, 0, A); v.e_st = 3'd1; v.e_ren = 1; v.e_ra = 32'h40;
    v.e_iw = 2'b10; v.e_il = {32'h0, LD}; tbl.push_back(v);
    // both icaches: lastgrant=0 so core 1, then core 0
    v = in_v(0, 2'b11, 0, 0, 0, 0, F); tbl.push_back(v);
    v = in_v(0, 2'b11, 0, 0, 0, 0, A); v.e_st = 3'd1; v.e_ren = 1; v.e_ra = 32'h80;
    v.e_iw = 2'b01; v.e_il = {LD, 32'h0}; tbl.push_back(v);
    v = in_v(0, 2'b01, 0, 0, 0, 0, F); tbl.push_back(v);
    v = in_v(0, 2'b01, 0, 0, 0, 0, A); v.e_st = 3'd1; v.e_ren = 1; v.e_ra = 32'h40;
    v.e_iw = 2'b10; v.e_il = {32'h0, LD}; tbl.push_back(v);
    // core 0 coherent write miss, core 1 clean: 2 snoop cycles then DREAD
    v = in_v(0, 0, 2'b01, 0, 2'b01, 2'b01, F); tbl.push_back(v);
    v = in_v(0, 0, 2'b01, 0, 2'b01, 2'b01, F); v.e_st = 3'd4; v.e_ccw = 2'b10; v.e_cci = 2'b10;
    v.e_snp = {32'h100, 32'h0}; tbl.push_back(v);
    v = in_v(0, 0, 2'b01, 0, 2'b01, 2'b01, F); v.e_st = 3'd4; v.e_ccw = 2'b10; v.e_cci = 2'b10;
    v.e_snp = {32'h100, 32'h0}; tbl.push_back(v);
    v = in_v(0, 0, 2'b01, 0, 2'b01, 2'b01, A); v.e_st = 3'd2; v.e_ren = 1; v.e_ra = 32'h100;
    v.e_dw = 2'b10; v.e_dl = {32'h0, LD}; tbl.push_back(v);
    // second miss word: plain DREAD, no re-snoop
    v = in_v(0, 0, 2'b01, 0, 0, 0, F); tbl.push_back(v);
    v = in_v(0, 0, 2'b01, 0, 0, 0, A); v.e_st = 3'd2; v.e_ren = 1; v.e_ra = 32'h100;
    v.e_dw = 2'b10; v.e_dl = {32'h0, LD}; tbl.push_back(v);
    // core 1 S->M upgrade: invalidate core 0, no RAM, back to IDLE
    v = in_v(0, 0, 0, 0, 2'b10, 2'b10, F); tbl.push_back(v);
    v = in_v(0, 0, 0, 0, 2'b10, 2'b10, F); v.e_st = 3'd4; v.e_ccw = 2'b01; v.e_cci = 2'b01;
    v.e_snp = {32'h0, 32'h200}; tbl.push_back(v);
    v = in_v(0, 0, 0, 0, 2'b10, 2'b10, F); v.e_st = 3'd4; v.e_ccw = 2'b01; v.e_cci = 2'b01;
    v.e_snp = {32'h0, 32'h200}; tbl.push_back(v);
    v = in_v(0, 0, 0, 0, 0, 0, F); tbl.push_back(v);
  endtask

  // Snoop phases of a core-0 coherent miss where core 1 holds the line dirty.
  task automatic start_dirty_miss(input string tag);
    dREN = 2'b01; cctrans = 2'b01; ccwrite = 2'b01; ramstate = F;
    @(negedge CLK);
    chk({tag, " idle state"}, dbg_state, 3'd0);
    next_cycle();
    @(negedge CLK);
    chk({tag, " snoop0 ccwait"}, ccwait, 2'b10);
    chk({tag, " snoop0 ccinv"}, ccinv, 2'b10);
    chk({tag, " snoop0 addr"}, ccsnoopaddr[1], 32'h100);
    next_cycle();
    cctrans = 2'b11; daddr[1] = 32'h100; dstore[1] = 32'hDEAD;
    @(negedge CLK);
    chk({tag, " snoop1 state"}, dbg_state, 3'd4);
    chk({tag, " snoop1 ram"}, {ramREN, ramWEN}, 2'b00);
    next_cycle();
  endtask

  initial begin
    int last;
    int exp_core;
    RST = 1'b1;
    iaddr = {32'h80, 32'h40};
    daddr = {32'h200, 32'h100};
    dstore = {32'hB0B0, 32'hA0A0};
    ramload = LD;
    clear_reqs();
    build_table();
    next_cycle();

    // Table: drive after the rising edge, compare on the falling edge.
    for (int i = 0; i < tbl.size(); i++) begin
      RST = tbl[i].rst; iREN = tbl[i].iren; dREN = tbl[i].dren; dWEN = tbl[i].dwen;
      cctrans = tbl[i].cct; ccwrite = tbl[i].ccw; ramstate = tbl[i].rs;
      @(negedge CLK);
      chk($sformatf("v%0d state", i), dbg_state, tbl[i].e_st);
      chk($sformatf("v%0d iwait", i), iwait, tbl[i].e_iw);
      chk($sformatf("v%0d dwait", i), dwait, tbl[i].e_dw);
      chk($sformatf("v%0d ccwait", i), ccwait, tbl[i].e_ccw);
      chk($sformatf("v%0d ccinv", i), ccinv, tbl[i].e_cci);
      chk($sformatf("v%0d ram_en", i), {ramREN, ramWEN}, {tbl[i].e_ren, tbl[i].e_wen});
      chk($sformatf("v%0d ramaddr", i), ramaddr, tbl[i].e_ra);
      chk($sformatf("v%0d ramstore", i), ramstore, tbl[i].e_rst);
      chk($sformatf("v%0d iload", i), iload, tbl[i].e_il);
      chk($sformatf("v%0d dload", i), dload, tbl[i].e_dl);
      chk($sformatf("v%0d snoopaddr", i), ccsnoopaddr, tbl[i].e_snp);
      next_cycle();
    end

    // Cache-to-cache block: DEAD then BEEF, write-back to 0x100/0x104.
    start_dirty_miss("c2c");
    ramstate = B;
    @(negedge CLK);
    chk("c2c x1 state", dbg_state, 3'd5);
    chk("c2c x1 busy dwait", dwait, 2'b11);
    chk("c2c x1 ramWEN", ramWEN, 1'b1);
    chk("c2c x1 ramaddr", ramaddr, 32'h100);
    chk("c2c x1 ramstore", ramstore, 32'hDEAD);
    chk("c2c x1 dload0", dload[0], 32'hDEAD);
    chk("c2c x1 ccwait", ccwait, 2'b10);
    next_cycle();
    ramstate = A;
    @(negedge CLK);
    chk("c2c x1 dwait", dwait, 2'b00);
    chk("c2c x1 acc dload0", dload[0], 32'hDEAD);
    chk("c2c x1 acc ramaddr", ramaddr, 32'h100);
    next_cycle();
    daddr[1] = 32'h104; dstore[1] = 32'hBEEF;
    @(negedge CLK);
    chk("c2c x2 state", dbg_state, 3'd6);
    chk("c2c x2 dwait", dwait, 2'b00);
    chk("c2c x2 dload0", dload[0], 32'hBEEF);
    chk("c2c x2 ramaddr", ramaddr, 32'h104);
    chk("c2c x2 ramstore", ramstore, 32'hBEEF);
    chk("c2c x2 ramWEN", ramWEN, 1'b1);
    next_cycle();
    clear_reqs();
    daddr[1] = 32'h200; dstore[1] = 32'hB0B0;
    @(negedge CLK);
    chk("c2c end state", dbg_state, 3'd0);
    chk("c2c end dwait", dwait, 2'b11);
    chk("c2c end ccwait", ccwait, 2'b00);
    chk("c2c end ramWEN", ramWEN, 1'b0);
    next_cycle();

    // Reset in XFER1 while RAM is BUSY.
    start_dirty_miss("rst");
    ramstate = B; RST = 1'b1;
    @(negedge CLK);
    chk("rst x1 ramWEN before edge", ramWEN, 1'b1);
    next_cycle();
    RST = 1'b0;
    clear_reqs();
    ramstate = B;
    daddr[1] = 32'h200; dstore[1] = 32'hB0B0;
    @(negedge CLK);
    chk("rst after state", dbg_state, 3'd0);
    chk("rst after ram_en", {ramREN, ramWEN}, 2'b00);
    chk("rst after iwait", iwait, 2'b11);
    chk("rst after dwait", dwait, 2'b11);
    chk("rst after ccwait", ccwait, 2'b00);
    chk("rst after ccinv", ccinv, 2'b00);
    chk("rst after ramaddr", ramaddr, 32'h0);
    chk("rst after dload", dload, 64'h0);
    next_cycle();

    // Fairness: both cores hammer dREN; grants alternate starting at core 1.
    last = 0;
    dREN = 2'b11; ramstate = A;
    for (int k = 0; k < 10; k++) begin
      exp_core = (last == 0) ? 1 : 0;
      last = exp_core;
      @(negedge CLK);
      chk($sformatf("rr%0d idle", k), dbg_state, 3'd0);
      next_cycle();
      @(negedge CLK);
      chk($sformatf("rr%0d dwait", k), dwait, (exp_core == 1) ? 2'b01 : 2'b10);
      chk($sformatf("rr%0d ramaddr", k), ramaddr, (exp_core == 1) ? 32'h200 : 32'h100);
      next_cycle();
    end
    clear_reqs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_controller.md
# bus_controller

Coherent memory bus controller for the dual-core pipeline. It sits between two cores' icache/dcache pairs and the single-ported RAM. It arbitrates word requests and drives snoop requests into the remote dcache. When the remote copy is modified, it performs the cache-to-cache transfer with a simultaneous RAM write-back. It is the responder side of the dcache's coherence handshake: dcache states SNOOPING / DATA_XFER1 / DATA_XFER2 / MISS1 / MISS2 talk to this block.

## Interface
No parameters; two cores fixed, word_t = 32 bits, blocks = 2 words.
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  one clock; reset is synchronous and active-high
- iREN  in  2  icache read request, per core
- iaddr  in  2x32  icache word address
- iwait  out  2  icache stall; 0 for exactly the data-valid cycle
- iload  out  2x32  icache read data (= ramload)
- dREN, dWEN  in  2 each  dcache read / write request
- daddr, dstore  in  2x32 each  dcache address / write data
- dwait  out  2  dcache stall; 0 for exactly the completion cycle
- dload  out  2x32  dcache read data
- cctrans  in  2  requester: coherence transaction (first word of a miss or upgrade); snoop target: "dirty hit" response
- ccwrite  in  2  requester intends to write (others must invalidate)
- ccwait  out  2  snoop request to that core's dcache
- ccinv  out  2  invalidate qualifier accompanying ccwait
- ccsnoopaddr  out  2x32  snoop address
- ramREN, ramWEN  out  1 each  RAM read / write enable
- ramaddr, ramstore  out  32 each  RAM address / write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3; ERROR treated as BUSY

## Operation
- State machine bus_state_t (3 bits): IDLE, IFETCH, DREAD, DWRITE, SNOOP, XFER1, XFER2.
- Registers: state, grant g (1 bit, requester index), lastgrant (1 bit), snoop phase bit, snooper j = ~g.
- IDLE arbitration:
  - Dcache requests (dREN|dWEN|cctrans) beat icache requests.
  - Among cores, if both request the same class, grant ~lastgrant; else grant the requester.
  - lastgrant updates on every grant.
- Dcache grant transitions, in order:
  - cctrans[g] → SNOOP.
  - dWEN[g] → DWRITE.
  - dREN[g] → DREAD.
- Icache grant transition: → IFETCH.
- IFETCH: ramREN=1, ramaddr=iaddr[g]. On ramstate==ACCESS: iwait[g]=0, then → IDLE.
- DREAD: ramREN=1, ramaddr=daddr[g]. On ACCESS: dwait[g]=0, dload[g]=ramload, then → IDLE.
- DWRITE: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g]. On ACCESS: dwait[g]=0, then → IDLE.
- SNOOP: ccwait[j]=1, ccsnoopaddr[j]=daddr[g], ccinv[j]=ccwrite[g]. Lasts exactly 2 cycles (phase 0, phase 1).
  - In phase 1, cctrans[j]=1 (dirty hit) → XFER1.
  - Otherwise: dREN[g]=1 → DREAD; dREN[g]=0 (S→M upgrade, invalidate only) → IDLE, dwait untouched.
- XFER1/XFER2: ccwait[j] held 1. Controller forwards and writes back at once:
  - dload[g]=dstore[j], ramWEN=1, ramaddr=daddr[j], ramstore=dstore[j].
  - On ACCESS: dwait[g]=0 and dwait[j]=0 in the same cycle; XFER1 → XFER2, XFER2 → IDLE.
  - The requester's second miss word is consumed in XFER2 and is not re-requested.
- A non-cctrans dREN issued for the second word after an RAM-sourced miss is served as a plain DREAD; there is no re-snoop.
- Outputs are combinational from state, g, and inputs. Defaults outside the cases above: waits = 1, ccwait/ccinv = 0, ram enables = 0, addresses/data = 0.

## Timing
- Reset (RST high at edge): state=IDLE, lastgrant=0, phase=0.
  - Outputs next cycle: iwait=2'b11, dwait=2'b11, ccwait=0, ccinv=0, ramREN=ramWEN=0, all data/address outputs 0.
- Reset mid-transaction aborts immediately. RAM enables drop in the cycle after the reset edge, and no wait is released.
- Grant to first RAM enable: 1 cycle (IDLE registers g).
- Minimum latencies with RAM returning ACCESS in the first enabled cycle:
  - read/write: 2 cycles request-to-wait-low;
  - snoop miss + read: 4 cycles;
  - cache-to-cache block: 5 cycles.
- RAM enables and addresses are held stable until ACCESS. An enable is never deasserted while BUSY.
- Waits are low for exactly one cycle per completed word; the state leaves on the same edge.
- Requests arriving during a non-IDLE state are ignored until IDLE. The snoop target's own pending request waits.
- Simultaneous iREN and dREN on the same core: dcache served first; icache served at the next IDLE.

## Test plan
- Reset, then iREN=2'b01, iaddr[0]=0x40, RAM ACCESS after 2 BUSY cycles → iwait[0] low exactly once, iload[0]=ramload; iwait[1] stays 1.
- Both cores dREN on the same cycle after reset → core 1 served first (lastgrant=0), then core 0; no starvation over 10 alternating back-to-back requests.
- Core 0 cctrans+dREN+ccwrite, daddr=0x100; core 1 responds cctrans=0 → ccwait[1]=ccinv[1]=1 for 2 cycles, then ramREN with ramaddr=0x100.
- Same, but core 1 responds cctrans=1 with dstore 0xDEAD/0xBEEF → dload[0]=0xDEAD then 0xBEEF; ramWEN to 0x100/0x104; dwait[0] and dwait[1] low together twice.
- Upgrade: cctrans[1]=1, ccwrite[1]=1, dREN=0 → ccinv[0]=1 for 2 cycles, return to IDLE, no RAM enable, dwait unchanged.
- RST asserted during XFER1 with RAM BUSY → next cycle ramWEN=0, all waits 1, ccwait 0, state IDLE.
